// File: rtl/ws281x_pkg.sv
// -----------------------------------------------------------------------------
// ws281x_pkg
// Shared definitions for the WS281X branch sequencer:
//   - sequencer state encoding (WAIT_SYNC, LATCH, RUN, DRAIN)
//   - default geometry (branch count, select width, length width, reset length)
//   - ESC_NEXT_BRANCH, the in-band node value that forces a branch advance
//     when the build defines WS281X_ESC_ADVANCE_EN
// -----------------------------------------------------------------------------
package ws281x_pkg;

   localparam int NUM_BR_DEF  = 16;
   localparam int SEL_W_DEF   = 4;
   localparam int LEN_W_DEF   = 12;
   localparam int DEF_LEN_DEF = 50;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      LATCH     = 2'd1,
      RUN       = 2'd2,
      DRAIN     = 2'd3
   } seq_state_e;

   localparam logic [23:0] ESC_NEXT_BRANCH = 24'h010203;

endpackage : ws281x_pkg

// File: rtl/ws281x_len_table.sv
// -----------------------------------------------------------------------------
// ws281x_len_table
// Per-branch length table: NUM_BR entries of LEN_W bits, every entry resets to
// DEF_LEN. One synchronous write port, one combinational read port (indexed by
// the current branch select) and a nonzero mask used by the branch search.
//
// Ports:
//   Clock      in   system clock, rising edge
//   nReset     in   asynchronous active-low reset
//   wr_en_i    in   write enable
//   wr_addr_i  in   entry to write; addresses >= NUM_BR are dropped
//   wr_data_i  in   new length (0 = branch skipped)
//   rd_addr_i  in   entry to read
//   rd_len_o   out  length of entry rd_addr_i
//   nz_mask_o  out  bit i set when entry i is nonzero
// -----------------------------------------------------------------------------
module ws281x_len_table
   import ws281x_pkg::*;
#(
   parameter int NUM_BR  = NUM_BR_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int LEN_W   = LEN_W_DEF,
   parameter int DEF_LEN = DEF_LEN_DEF
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              wr_en_i,
   input  logic [SEL_W-1:0]  wr_addr_i,
   input  logic [LEN_W-1:0]  wr_data_i,
   input  logic [SEL_W-1:0]  rd_addr_i,
   output logic [LEN_W-1:0]  rd_len_o,
   output logic [NUM_BR-1:0] nz_mask_o
);

   logic [LEN_W-1:0] len_q [NUM_BR];

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < NUM_BR; i++) begin
            len_q[i] <= LEN_W'(DEF_LEN);
         end
      end else if (wr_en_i && (int'(wr_addr_i) < NUM_BR)) begin
         len_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Out-of-range select (only possible when NUM_BR < 2**SEL_W) reads as a
   // skipped branch.
   assign rd_len_o = (int'(rd_addr_i) < NUM_BR) ? len_q[rd_addr_i] : '0;

   for (genvar gi = 0; gi < NUM_BR; gi++) begin : g_nz
      assign nz_mask_o[gi] = |len_q[gi];
   end

endmodule : ws281x_len_table

// File: rtl/ws281x_branch_sequencer.sv
// -----------------------------------------------------------------------------
// ws281x_branch_sequencer
// Decides which branch string of the WS281X splitter receives incoming nodes.
// A latch interval (SyncIn high) starts a frame; on its release the first
// nonzero-length branch is selected. Each completed node is counted against
// that branch's length; when the branch is full the select moves upward to
// the next nonzero branch, and after the last one FrameDone pulses and the
// demux is disabled. Nodes arriving after frame completion set Overflow.
//
// Build option: define WS281X_ESC_ADVANCE_EN to make a node equal to
// ESC_NEXT_BRANCH jump to the next branch immediately (that node is not
// counted). Without it Node is ignored.
//
// Ports:
//   Clock      in   system clock, rising edge
//   nReset     in   asynchronous active-low reset
//   NodeValid  in   one-cycle strobe, a 24-bit node was completed
//   Node       in   completed node value (escape detection only)
//   SyncIn     in   high while the latch interval is detected
//   CfgWe      in   length-table write enable
//   CfgAddr    in   branch index to write
//   CfgData    in   branch length in nodes (0 = skipped)
//   BranchSel  out  current branch index for the demux
//   BranchEn   out  demux enable
//   NodeIndex  out  nodes already delivered to the current branch
//   FrameDone  out  one-cycle pulse when the last enabled branch is filled
//   Overflow   out  sticky, nodes arrived after frame completion
// -----------------------------------------------------------------------------
module ws281x_branch_sequencer
   import ws281x_pkg::*;
#(
   parameter int NUM_BR  = NUM_BR_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int LEN_W   = LEN_W_DEF,
   parameter int DEF_LEN = DEF_LEN_DEF
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             NodeValid,
   input  logic [23:0]      Node,
   input  logic             SyncIn,
   input  logic             CfgWe,
   input  logic [SEL_W-1:0] CfgAddr,
   input  logic [LEN_W-1:0] CfgData,
   output logic [SEL_W-1:0] BranchSel,
   output logic             BranchEn,
   output logic [LEN_W-1:0] NodeIndex,
   output logic             FrameDone,
   output logic             Overflow
);

   seq_state_e       state_q, state_d;
   logic [SEL_W-1:0] sel_q,   sel_d;
   logic             en_q,    en_d;
   logic [LEN_W-1:0] idx_q,   idx_d;
   logic             done_q,  done_d;
   logic             ovf_q,   ovf_d;

   logic [LEN_W-1:0]  cur_len;
   logic [NUM_BR-1:0] nz_mask;

   ws281x_len_table #(
      .NUM_BR  (NUM_BR),
      .SEL_W   (SEL_W),
      .LEN_W   (LEN_W),
      .DEF_LEN (DEF_LEN)
   ) u_len_table (
      .Clock     (Clock),
      .nReset    (nReset),
      .wr_en_i   (CfgWe),
      .wr_addr_i (CfgAddr),
      .wr_data_i (CfgData),
      .rd_addr_i (sel_q),
      .rd_len_o  (cur_len),
      .nz_mask_o (nz_mask)
   );

   // Priority searches over the nonzero mask. Scanning downward lets the
   // lowest matching index overwrite earlier hits.
   logic             first_found;
   logic [SEL_W-1:0] first_idx;
   logic             next_found;
   logic [SEL_W-1:0] next_idx;

   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int i = NUM_BR - 1; i >= 0; i--) begin
         if (nz_mask[i]) begin
            first_found = 1'b1;
            first_idx   = SEL_W'(i);
         end
         if (nz_mask[i] && (i > int'(sel_q))) begin
            next_found = 1'b1;
            next_idx   = SEL_W'(i);
         end
      end
   end

   // One extra bit so the compare is exact even at the maximum length. Using
   // >= means a length shrunk below the current count (including 0) ends the
   // branch on the very next node.
   logic [LEN_W:0]   idx_plus1;
   logic             branch_full;
   logic [LEN_W-1:0] idx_sat;

   assign idx_plus1   = {1'b0, idx_q} + 1'b1;
   assign branch_full = (idx_plus1 >= {1'b0, cur_len});
   assign idx_sat     = (&idx_q) ? idx_q : idx_plus1[LEN_W-1:0];

   logic esc_hit;
`ifdef WS281X_ESC_ADVANCE_EN
   assign esc_hit = (Node == ESC_NEXT_BRANCH);
`else
   logic unused_node;
   assign esc_hit     = 1'b0;
   assign unused_node = ^Node;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      en_d    = en_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;

      case (state_q)
         WAIT_SYNC: begin
            en_d = 1'b0;
            if (SyncIn) begin
               state_d = LATCH;
               idx_d   = '0;
               ovf_d   = 1'b0;
            end
         end

         LATCH: begin
            en_d  = 1'b0;
            idx_d = '0;
            // SyncIn low here is the 1->0 edge: LATCH is only entered with it high.
            if (!SyncIn) begin
               if (first_found) begin
                  state_d = RUN;
                  sel_d   = first_idx;
                  en_d    = 1'b1;
               end else begin
                  state_d = DRAIN;
                  done_d  = 1'b1;
               end
            end
         end

         RUN: begin
            // Sync takes priority over a node in the same cycle.
            if (SyncIn) begin
               state_d = LATCH;
               en_d    = 1'b0;
               idx_d   = '0;
               ovf_d   = 1'b0;
            end else if (NodeValid) begin
               if (esc_hit || branch_full) begin
                  if (next_found) begin
                     sel_d = next_idx;
                     idx_d = '0;
                  end else begin
                     state_d = DRAIN;
                     en_d    = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  idx_d = idx_sat;
               end
            end
         end

         DRAIN: begin
            en_d = 1'b0;
            if (SyncIn) begin
               state_d = LATCH;
               idx_d   = '0;
               ovf_d   = 1'b0;
            end else if (NodeValid) begin
               ovf_d = 1'b1;
            end
         end

         default: begin
            state_d = WAIT_SYNC;
            en_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= WAIT_SYNC;
         sel_q   <= '0;
         en_q    <= 1'b0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign BranchSel = sel_q;
   assign BranchEn  = en_q;
   assign NodeIndex = idx_q;
   assign FrameDone = done_q;
   assign Overflow  = ovf_q;

endmodule : ws281x_branch_sequencer

// File: tb/tb_ws281x_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ws281x_branch_sequencer
// Self-checking bench. The reference model expands the length table into a
// flat list of (branch, delivered-count) positions for a frame; after n nodes
// the expected select/index is entry n of that list, n == total means the
// FrameDone pulse, and n > total means Overflow.
// -----------------------------------------------------------------------------
module tb_ws281x_branch_sequencer;

   localparam int NUM_BR  = 16;
   localparam int SEL_W   = 4;
   localparam int LEN_W   = 12;
   localparam int DEF_LEN = 50;

   logic             Clock = 1'b0;
   logic             nReset;
   logic             NodeValid;
   logic [23:0]      Node;
   logic             SyncIn;
   logic             CfgWe;
   logic [SEL_W-1:0] CfgAddr;
   logic [LEN_W-1:0] CfgData;
   logic [SEL_W-1:0] BranchSel;
   logic             BranchEn;
   logic [LEN_W-1:0] NodeIndex;
   logic             FrameDone;
   logic             Overflow;

   ws281x_branch_sequencer #(
      .NUM_BR  (NUM_BR),
      .SEL_W   (SEL_W),
      .LEN_W   (LEN_W),
      .DEF_LEN (DEF_LEN)
   ) dut (
      .Clock     (Clock),
      .nReset    (nReset),
      .NodeValid (NodeValid),
      .Node      (Node),
      .SyncIn    (SyncIn),
      .CfgWe     (CfgWe),
      .CfgAddr   (CfgAddr),
      .CfgData   (CfgData),
      .BranchSel (BranchSel),
      .BranchEn  (BranchEn),
      .NodeIndex (NodeIndex),
      .FrameDone (FrameDone),
      .Overflow  (Overflow)
   );

   always #5 Clock = ~Clock;

   int checks   = 0;
   int failures = 0;

   int m_len[NUM_BR];
   int fb[$];
   int fi[$];

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [23:0] rand_node();
      logic [23:0] v;
      v = 24'($urandom);
      if (v == 24'h010203) v = 24'h000000;
      return v;
   endfunction

   task automatic cfg_write(input int a, input int d);
      CfgWe   = 1'b1;
      CfgAddr = SEL_W'(a);
      CfgData = LEN_W'(d);
      tick();
      CfgWe   = 1'b0;
      if (a < NUM_BR) m_len[a] = d;
   endtask

   task automatic set_all(input int d);
      for (int i = 0; i < NUM_BR; i++) cfg_write(i, d);
   endtask

   task automatic send_node(input logic [23:0] v);
      NodeValid = 1'b1;
      Node      = v;
      tick();
      NodeValid = 1'b0;
   endtask

   task automatic sync_release();
      SyncIn = 1'b1;
      tick();
      tick();
      SyncIn = 1'b0;
      tick();
   endtask

   task automatic build_flat();
      fb.delete();
      fi.delete();
      for (int b = 0; b < NUM_BR; b++)
         for (int k = 0; k < m_len[b]; k++) begin
            fb.push_back(b);
            fi.push_back(k);
         end
   endtask

   // Full frame: sync, release, total+extra nodes, all checked against the model.
   task automatic run_frame(input string name, input int extra, input bit gaps);
      int total;
      build_flat();
      total = fb.size();

      SyncIn = 1'b1;
      tick();
      tick();
      checks++;
      if ({BranchEn, NodeIndex, FrameDone, Overflow} !== {1'b0, LEN_W'(0), 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL %s latch: got en=%0b idx=%0d done=%0b ovf=%0b, expected en=0 idx=0 done=0 ovf=0",
                  name, BranchEn, NodeIndex, FrameDone, Overflow);
      end

      SyncIn = 1'b0;
      tick();
      checks++;
      if (total == 0) begin
         if ({BranchEn, FrameDone} !== 2'b01) begin
            failures++;
            $display("FAIL %s release: got en=%0b done=%0b, expected en=0 done=1",
                     name, BranchEn, FrameDone);
         end
      end else if ({BranchEn, BranchSel, NodeIndex, FrameDone} !==
                   {1'b1, SEL_W'(fb[0]), LEN_W'(0), 1'b0}) begin
         failures++;
         $display("FAIL %s release: got en=%0b sel=%0d idx=%0d done=%0b, expected en=1 sel=%0d idx=0 done=0",
                  name, BranchEn, BranchSel, NodeIndex, FrameDone, fb[0]);
      end

      for (int n = 1; n <= total + extra; n++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         send_node(rand_node());
         checks++;
         if (n < total) begin
            if ({BranchEn, BranchSel, NodeIndex, FrameDone, Overflow} !==
                {1'b1, SEL_W'(fb[n]), LEN_W'(fi[n]), 1'b0, 1'b0}) begin
               failures++;
               $display("FAIL %s node %0d: got en=%0b sel=%0d idx=%0d done=%0b ovf=%0b, expected en=1 sel=%0d idx=%0d done=0 ovf=0",
                        name, n, BranchEn, BranchSel, NodeIndex, FrameDone, Overflow, fb[n], fi[n]);
            end
         end else begin
            if ({BranchEn, FrameDone, Overflow} !== {1'b0, n == total, n > total}) begin
               failures++;
               $display("FAIL %s node %0d: got en=%0b done=%0b ovf=%0b, expected en=0 done=%0b ovf=%0b",
                        name, n, BranchEn, FrameDone, Overflow, n == total, n > total);
            end
         end
      end

      tick();
      checks++;
      if (FrameDone !== 1'b0) begin
         failures++;
         $display("FAIL %s done_width: got done=%0b, expected 0", name, FrameDone);
      end
   endtask

   task automatic test_reset();
      nReset    = 1'b0;
      NodeValid = 1'b0;
      Node      = '0;
      SyncIn    = 1'b0;
      CfgWe     = 1'b0;
      CfgAddr   = '0;
      CfgData   = '0;
      for (int i = 0; i < NUM_BR; i++) m_len[i] = DEF_LEN;
      repeat (3) tick();
      checks++;
      if ({BranchSel, BranchEn, NodeIndex, FrameDone, Overflow} !== '0) begin
         failures++;
         $display("FAIL reset: got sel=%0d en=%0b idx=%0d done=%0b ovf=%0b, expected all 0",
                  BranchSel, BranchEn, NodeIndex, FrameDone, Overflow);
      end
      nReset = 1'b1;
      tick();
      send_node(rand_node());
      send_node(rand_node());
      checks++;
      if ({BranchEn, FrameDone, Overflow} !== 3'b000) begin
         failures++;
         $display("FAIL pre_sync_nodes: got en=%0b done=%0b ovf=%0b, expected 0 0 0",
                  BranchEn, FrameDone, Overflow);
      end
   endtask

   task automatic test_default_frame();
      run_frame("default", 0, 1'b0);
   endtask

   task automatic test_sparse();
      set_all(0);
      cfg_write(1, 3);
      run_frame("sparse", 1, 1'b1);
   endtask

   task automatic test_all_zero();
      set_all(0);
      run_frame("allzero", 1, 1'b0);
   endtask

   task automatic test_shrink();
      set_all(50);
      cfg_write(0, 10);
      sync_release();
      repeat (4) send_node(rand_node());
      cfg_write(0, 2);
      checks++;
      if ({BranchEn, BranchSel, NodeIndex} !== {1'b1, SEL_W'(0), LEN_W'(4)}) begin
         failures++;
         $display("FAIL shrink_hold: got en=%0b sel=%0d idx=%0d, expected en=1 sel=0 idx=4",
                  BranchEn, BranchSel, NodeIndex);
      end
      send_node(rand_node());
      checks++;
      if ({BranchEn, BranchSel, NodeIndex} !== {1'b1, SEL_W'(1), LEN_W'(0)}) begin
         failures++;
         $display("FAIL shrink_adv: got en=%0b sel=%0d idx=%0d, expected en=1 sel=1 idx=0",
                  BranchEn, BranchSel, NodeIndex);
      end
   endtask

   task automatic test_early_sync();
      set_all(50);
      sync_release();
      repeat (20) send_node(rand_node());
      checks++;
      if ({BranchSel, NodeIndex} !== {SEL_W'(0), LEN_W'(20)}) begin
         failures++;
         $display("FAIL early_pre: got sel=%0d idx=%0d, expected sel=0 idx=20", BranchSel, NodeIndex);
      end
      SyncIn    = 1'b1;
      NodeValid = 1'b1;
      Node      = rand_node();
      tick();
      NodeValid = 1'b0;
      checks++;
      if ({BranchEn, NodeIndex, FrameDone} !== {1'b0, LEN_W'(0), 1'b0}) begin
         failures++;
         $display("FAIL early_latch: got en=%0b idx=%0d done=%0b, expected en=0 idx=0 done=0",
                  BranchEn, NodeIndex, FrameDone);
      end
      tick();
      checks++;
      if (FrameDone !== 1'b0) begin
         failures++;
         $display("FAIL early_nodone: got done=%0b, expected 0", FrameDone);
      end
      SyncIn = 1'b0;
      tick();
      checks++;
      if ({BranchEn, BranchSel, NodeIndex} !== {1'b1, SEL_W'(0), LEN_W'(0)}) begin
         failures++;
         $display("FAIL early_release: got en=%0b sel=%0d idx=%0d, expected en=1 sel=0 idx=0",
                  BranchEn, BranchSel, NodeIndex);
      end
   endtask

   task automatic test_escape();
      int exp_sel;
      int exp_idx;
      set_all(50);
      sync_release();
      repeat (4) send_node(rand_node());
      send_node(24'h010203);
`ifdef WS281X_ESC_ADVANCE_EN
      exp_sel = 1;
      exp_idx = 0;
`else
      exp_sel = 0;
      exp_idx = 5;
`endif
      checks++;
      if ({BranchEn, BranchSel, NodeIndex} !== {1'b1, SEL_W'(exp_sel), LEN_W'(exp_idx)}) begin
         failures++;
         $display("FAIL escape: got en=%0b sel=%0d idx=%0d, expected en=1 sel=%0d idx=%0d",
                  BranchEn, BranchSel, NodeIndex, exp_sel, exp_idx);
      end
      send_node(rand_node());
      checks++;
      if ({BranchSel, NodeIndex} !== {SEL_W'(exp_sel), LEN_W'(exp_idx + 1)}) begin
         failures++;
         $display("FAIL escape_next: got sel=%0d idx=%0d, expected sel=%0d idx=%0d",
                  BranchSel, NodeIndex, exp_sel, exp_idx + 1);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
         for (int b = 0; b < NUM_BR; b++) begin
            if ($urandom_range(0, 2) == 0) cfg_write(b, 0);
            else cfg_write(b, $urandom_range(1, 6));
         end
         run_frame("random", $urandom_range(0, 2), 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_default_frame();
      test_sparse();
      test_all_zero();
      test_shrink();
      test_early_sync();
      test_escape();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ws281x_branch_sequencer
